// File: rtl/hazard_detection_unit_pkg.sv
// Shared constants and types for the MIPS pipeline hazard controller.
// Register-zero encoding, busy-counter width and the pipeline control bundle live here.
package hazard_detection_unit_pkg;

    localparam logic [4:0]  REG_ZERO           = 5'd0;
    localparam int unsigned BUSY_W             = 4;
    localparam int unsigned DEF_MULDIV_LATENCY = 4;

    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic ifid_flush;
        logic idex_flush;
        logic ctl_mux_sel;
    } hazard_ctl_t;

    localparam hazard_ctl_t CTL_RUN    = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    localparam hazard_ctl_t CTL_STALL  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    localparam hazard_ctl_t CTL_BRANCH = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

endpackage

// File: rtl/hazard_detection_unit_muldiv_busy_counter.sv
// Countdown of cycles left before HI/LO holds a valid mult/div result.
// A load always wins over the decrement so back-to-back acceptances simply restart the count.
module muldiv_busy_counter
    import hazard_detection_unit_pkg::*;
#(
    parameter int unsigned LATENCY = DEF_MULDIV_LATENCY
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic busy
);

    logic [BUSY_W-1:0] cnt_q;
    logic [BUSY_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = BUSY_W'(LATENCY);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busy = (cnt_q != '0);

endmodule

// File: rtl/hazard_detection_unit.sv
// Load-use / HI-LO hazard detection and taken-branch flush control for the 5-stage MIPS pipe.
// All control outputs are combinational; only the mult/div countdown and the stall counter are state.
module hazard_detection_unit
    import hazard_detection_unit_pkg::*;
#(
    parameter int unsigned MULDIV_LATENCY = DEF_MULDIV_LATENCY,
    parameter int unsigned CNT_W          = 16
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [4:0]       ID_Rs,
    input  logic [4:0]       ID_Rt,
    input  logic             ID_UsesRt,
    input  logic             ID_MulDivStart,
    input  logic             ID_ReadsHiLo,
    input  logic             EX_MemRead,
    input  logic [4:0]       EX_Rt,
    input  logic             EX_BranchTaken,
    output logic             PCWrite,
    output logic             IFIDWrite,
    output logic             IFIDFlush,
    output logic             IDEXFlush,
    output logic             ControlMuxSel,
    output logic             MulDivBusy,
    output logic [CNT_W-1:0] StallCycles
);

    logic        busy_raw;
    logic        busy;
    logic        load_use;
    logic        hilo_haz;
    logic        stall;
    logic        branch;
    logic        muldiv_load;
    hazard_ctl_t ctl;

    logic [CNT_W-1:0] stall_cycles_q;
    logic [CNT_W-1:0] stall_cycles_d;

    muldiv_busy_counter #(
        .LATENCY (MULDIV_LATENCY)
    ) u_busy_cnt (
        .clk  (Clk),
        .rst  (Rst),
        .load (muldiv_load),
        .busy (busy_raw)
    );

    // Reset masks every hazard so the pipe free-runs while Rst is held.
    always_comb begin
        busy     = busy_raw & ~Rst;
        branch   = EX_BranchTaken & ~Rst;
        load_use = EX_MemRead & (EX_Rt != REG_ZERO) &
                   ((EX_Rt == ID_Rs) | (ID_UsesRt & (EX_Rt == ID_Rt)));
        hilo_haz = busy & (ID_ReadsHiLo | ID_MulDivStart);
        stall    = (load_use | hilo_haz) & ~branch & ~Rst;
        // A mult/div squashed by the branch never reaches EX, so it must not occupy HI/LO.
        muldiv_load = ID_MulDivStart & ~stall & ~branch & ~Rst;
    end

    always_comb begin
        ctl = CTL_RUN;
        if (branch) begin
            ctl = CTL_BRANCH;
        end else if (stall) begin
            ctl = CTL_STALL;
        end
    end

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (stall && (stall_cycles_q != {CNT_W{1'b1}})) begin
            stall_cycles_d = stall_cycles_q + 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            stall_cycles_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign PCWrite       = ctl.pc_write;
    assign IFIDWrite     = ctl.ifid_write;
    assign IFIDFlush     = ctl.ifid_flush;
    assign IDEXFlush     = ctl.idex_flush;
    assign ControlMuxSel = ctl.ctl_mux_sel;
    assign MulDivBusy    = busy;
    assign StallCycles   = stall_cycles_q;

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Scoreboard bench: stimulus pushes expected outputs from a cycle-count model, a negedge monitor compares.
module tb_hazard_detection_unit;

    localparam int LAT   = 4;
    localparam int CNT_W = 16;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             Clk;
    logic             Rst;
    logic [4:0]       ID_Rs, ID_Rt, EX_Rt;
    logic             ID_UsesRt, ID_MulDivStart, ID_ReadsHiLo, EX_MemRead, EX_BranchTaken;
    logic             PCWrite, IFIDWrite, IFIDFlush, IDEXFlush, ControlMuxSel, MulDivBusy;
    logic [CNT_W-1:0] StallCycles;

    hazard_detection_unit #(.MULDIV_LATENCY(LAT), .CNT_W(CNT_W)) dut (
        .Clk(Clk), .Rst(Rst), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRt(ID_UsesRt),
        .ID_MulDivStart(ID_MulDivStart), .ID_ReadsHiLo(ID_ReadsHiLo),
        .EX_MemRead(EX_MemRead), .EX_Rt(EX_Rt), .EX_BranchTaken(EX_BranchTaken),
        .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .IFIDFlush(IFIDFlush), .IDEXFlush(IDEXFlush),
        .ControlMuxSel(ControlMuxSel), .MulDivBusy(MulDivBusy), .StallCycles(StallCycles)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        bit rst, ur, ms, rh, mr, br;
        bit [4:0] rs, rt, ert;
    } stim_t;

    typedef struct {
        bit pcw, ifidw, ifidf, idexf, cms, busy;
        int cnt;
    } exp_t;

    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;
    // Model state: cycles of HI/LO occupancy left, and the stall count.
    int   m_left = 0;
    int   m_cnt  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge Clk) begin
        if (sbq.size() > 0) begin
            exp_t e;
            e = sbq.pop_front();
            chk("PCWrite",       32'(PCWrite),       32'(e.pcw));
            chk("IFIDWrite",     32'(IFIDWrite),     32'(e.ifidw));
            chk("IFIDFlush",     32'(IFIDFlush),     32'(e.ifidf));
            chk("IDEXFlush",     32'(IDEXFlush),     32'(e.idexf));
            chk("ControlMuxSel", 32'(ControlMuxSel), 32'(e.cms));
            chk("MulDivBusy",    32'(MulDivBusy),    32'(e.busy));
            chk("StallCycles",   32'(StallCycles),   32'(e.cnt));
        end
    end

    function automatic stim_t idle();
        stim_t s;
        s = '{default: 0};
        return s;
    endfunction

    task automatic step(input stim_t s, input bit push);
        exp_t e;
        bit busy, lu, hz, st;
        @(posedge Clk);
        #1;
        Rst = s.rst; ID_Rs = s.rs; ID_Rt = s.rt; ID_UsesRt = s.ur;
        ID_MulDivStart = s.ms; ID_ReadsHiLo = s.rh; EX_MemRead = s.mr;
        EX_Rt = s.ert; EX_BranchTaken = s.br;
        if (s.rst) begin
            e = '{1, 1, 0, 0, 0, 0, m_cnt};
            m_left = 0;
            m_cnt  = 0;
        end else begin
            busy = (m_left > 0);
            lu   = s.mr && (s.ert != 0) && ((s.ert == s.rs) || (s.ur && s.ert == s.rt));
            hz   = busy && (s.rh || s.ms);
            st   = (lu || hz) && !s.br;
            if (s.br)      e = '{1, 1, 1, 1, 1, 0, 0};
            else if (st)   e = '{0, 0, 0, 0, 1, 0, 0};
            else           e = '{1, 1, 0, 0, 0, 0, 0};
            e.busy = busy;
            e.cnt  = m_cnt;
            if (s.ms && !st && !s.br) m_left = LAT;
            else if (m_left > 0)      m_left = m_left - 1;
            if (st && m_cnt < CMAX)   m_cnt = m_cnt + 1;
        end
        if (push) sbq.push_back(e);
    endtask

    initial begin
        stim_t s;
        Rst = 1'b1; ID_Rs = '0; ID_Rt = '0; EX_Rt = '0; ID_UsesRt = 0;
        ID_MulDivStart = 0; ID_ReadsHiLo = 0; EX_MemRead = 0; EX_BranchTaken = 0;

        s = idle(); s.rst = 1;
        step(s, 0);
        step(s, 1);

        // Load-use on rs, then clear.
        s = idle(); s.mr = 1; s.ert = 5'd8; s.rs = 5'd8;
        step(s, 1);
        step(idle(), 1);
        // Load to $zero never stalls.
        s = idle(); s.mr = 1; s.ert = 5'd0; s.rs = 5'd0; s.ur = 1;
        step(s, 1);
        // Load-use via rt.
        s = idle(); s.mr = 1; s.ert = 5'd9; s.rs = 5'd1; s.rt = 5'd9; s.ur = 1;
        step(s, 1);
        s.ur = 0;
        step(s, 1);
        // mult accepted then mfhi waits out the latency.
        s = idle(); s.ms = 1;
        step(s, 1);
        s = idle(); s.rh = 1;
        repeat (LAT + 1) step(s, 1);
        // Load-use coincident with a taken branch.
        s = idle(); s.mr = 1; s.ert = 5'd8; s.rs = 5'd8; s.br = 1;
        step(s, 1);
        // mult squashed by a branch leaves HI/LO free.
        s = idle(); s.ms = 1; s.br = 1;
        step(s, 1);
        step(idle(), 1);
        // Reset in the middle of a mult/div countdown.
        s = idle(); s.ms = 1;
        step(s, 1);
        step(idle(), 1);
        s = idle(); s.rst = 1;
        step(s, 1);
        s = idle(); s.rh = 1;
        step(s, 1);
        // Back-to-back mult.
        s = idle(); s.ms = 1;
        repeat (2 * LAT + 3) step(s, 1);

        // Randomized traffic with narrow register ranges to force matches.
        for (int i = 0; i < 3000; i++) begin
            s.rst = ($urandom_range(0, 63) == 0);
            s.rs  = 5'($urandom_range(0, 3));
            s.rt  = 5'($urandom_range(0, 3));
            s.ert = 5'($urandom_range(0, 3));
            s.ur  = 1'($urandom);
            s.ms  = ($urandom_range(0, 5) == 0);
            s.rh  = ($urandom_range(0, 2) == 0);
            s.mr  = 1'($urandom);
            s.br  = ($urandom_range(0, 7) == 0);
            step(s, 1);
        end

        // Saturation of the stall counter.
        s = idle(); s.rst = 1;
        step(s, 1);
        s = idle(); s.mr = 1; s.ert = 5'd8; s.rs = 5'd8;
        repeat (CMAX + 1 + 5) step(s, 1);
        step(idle(), 1);

        repeat (2) @(posedge Clk);
        chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
        chk("stall_saturated", 32'(StallCycles), 32'hFFFF);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
